// File: rtl/sft_pkg.sv
// Shared constants and the round-robin pick function for the shifter arbiter.
// Combinational helpers only; no latency or backpressure of their own.
package sft_pkg;

    localparam int D_WIDTH   = 16;
    localparam int SEL_WIDTH = 4;
    localparam int MAX_REQ   = 8;

    // One-hot grant: first set bit of valid, scanning from ptr upward, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                    input logic [2:0]         ptr,
                                                    input logic [3:0]         n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [3:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if ((4'(k) < n) && !found && valid[idx[2:0]]) begin
                g[idx[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sft_l_lofin.sv
// Logical left shifter, zero fill, result truncated to D_WIDTH.
// Purely combinational, no backpressure.
module sft_l_lofin
    import sft_pkg::*;
(
    input  logic [D_WIDTH-1:0]   din,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [D_WIDTH-1:0]   dout
);

    assign dout = din << sel;

endmodule

// File: rtl/sft_l_arb.sv
// Round-robin arbiter sharing one left shifter among N_REQ requesters.
// Latency 1 cycle (registered result), 1 op/cycle sustained.
// Backpressure: a held, undrained result deasserts every req_ready.
module sft_l_arb
    import sft_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]     req_data,
    input  logic [N_REQ*SEL_WIDTH-1:0]   req_sel,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [D_WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         rsp_ovf
);

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      gnt_idx;
    logic [MAX_REQ-1:0]   pick;
    logic                 pick_hi_unused;
    logic [N_REQ-1:0]     grant;
    logic [D_WIDTH-1:0]   op_data;
    logic [SEL_WIDTH-1:0] op_sel;
    logic [D_WIDTH-1:0]   shf_data;
    logic                 shf_ovf;
    logic                 can_acc;
    logic                 acc;

    assign pick           = rr_pick(MAX_REQ'(req_valid), 3'(ptr), 4'(N_REQ));
    assign pick_hi_unused = |(pick >> N_REQ);
    assign grant          = pick[N_REQ-1:0];

    // The output slot is free when empty or being drained this cycle.
    assign can_acc   = ~rsp_valid | rsp_ready;
    assign req_ready = (rst_n && can_acc) ? grant : '0;
    assign acc       = |(req_valid & req_ready);

    always_comb begin
        gnt_idx = '0;
        op_data = '0;
        op_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = ID_W'(i);
                op_data = req_data[i*D_WIDTH +: D_WIDTH];
                op_sel  = req_sel[i*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    sft_l_lofin u_shf (
        .din  (op_data),
        .sel  (op_sel),
        .dout (shf_data)
    );

    // Any set bit above the surviving window is lost by the shift.
    assign shf_ovf = |(op_data & ~({D_WIDTH{1'b1}} >> op_sel));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (acc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shf_data;
            rsp_id    <= gnt_idx;
            rsp_ovf   <= shf_ovf;
            ptr       <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
